// File: rtl/instr_prefetch_pkg.sv
// Shared fetch-path types: register/instruction words, fetch bundle, memory request.
// Decode reuses fetch_entry_t to receive {pc, raw} pairs.
package instr_prefetch_pkg;

  typedef logic [31:0] gpreg;
  typedef logic [31:0] instr;

  typedef struct packed {
    gpreg pc;
    instr raw;
  } fetch_entry_t;

  typedef struct packed {
    gpreg        a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
  } mem_req_t;

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with clear; used for the address queue and response buffer.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are fine.
module fifo_sync #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T slot [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = slot[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) slot[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Pipelined fetch stage: credit-limited memory reads, in-order response buffer,
// bypass to decode, and flush that drops responses of killed requests.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int BUF_DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pc_valid,
  output logic         pc_ready,
  input  gpreg         pc_data,
  output logic         fetched_valid,
  input  logic         fetched_ready,
  output fetch_entry_t fetched_data,
  input  logic         flush,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output mem_req_t     mem_req_data,
  input  logic         mem_resp_valid,
  output logic         mem_resp_ready,
  input  instr         mem_resp_data
);

  localparam int AW = $clog2(MAX_INFLIGHT + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam int SW = BW + 1;

  logic [AW-1:0] live;
  logic [AW-1:0] drop;
  logic [AW-1:0] drop_nxt;
  logic [BW-1:0] cnt;
  logic [SW-1:0] inflight;
  logic [SW-1:0] occupied;

  logic          can_issue;
  logic          issue;
  logic          resp_fire;
  logic          resp_drop;
  logic          resp_live;
  logic          bypass;
  logic          sel_buf;
  logic          sel_byp;
  logic          buf_push;
  logic          buf_pop;

  gpreg          addr_head;
  fetch_entry_t  buf_head;
  fetch_entry_t  resp_entry;

  assign inflight = SW'(live) + SW'(drop);
  assign occupied = SW'(live) + SW'(cnt);

  assign can_issue = !rst && !flush
                  && (inflight < SW'(MAX_INFLIGHT))
                  && (occupied < SW'(BUF_DEPTH));

  assign mem_req_valid = pc_valid && can_issue;
  assign pc_ready      = mem_req_ready && can_issue;
  assign issue         = pc_valid && pc_ready;

  assign mem_req_data = '{a: pc_data, we: 1'b0, be: 4'hf, d: 32'h0};

  // Killed requests are answered first, so any drop credit claims the response.
  assign mem_resp_ready = 1'b1;
  assign resp_fire      = mem_resp_valid;
  assign resp_drop      = resp_fire && (drop != '0);
  assign resp_live      = resp_fire && !flush
                       && (drop == '0) && (live != '0);

  assign resp_entry = '{pc: addr_head, raw: mem_resp_data};

  assign bypass  = resp_live && (cnt == '0);
  assign sel_buf = !flush && (cnt != '0);
  assign sel_byp = !flush && bypass;

  always_comb begin
    fetched_valid = 1'b0;
    fetched_data  = buf_head;
    unique case (1'b1)
      sel_buf: fetched_valid = 1'b1;
      sel_byp: begin
        fetched_valid = 1'b1;
        fetched_data  = resp_entry;
      end
      default: ;
    endcase
  end

  assign buf_pop  = sel_buf && fetched_ready;
  assign buf_push = resp_live && !(bypass && fetched_ready);

  // Flush turns every live request into a drop credit.
  always_comb begin
    drop_nxt = drop;
    if (flush) begin
      drop_nxt = AW'(inflight - SW'(resp_fire && (inflight != '0)));
    end else if (resp_drop) begin
      drop_nxt = drop - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop <= '0;
    else     drop <= drop_nxt;
  end

  fifo_sync #(
    .T     (gpreg),
    .DEPTH (MAX_INFLIGHT)
  ) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (issue),
    .din   (pc_data),
    .pop   (resp_live),
    .head  (addr_head),
    .count (live)
  );

  fifo_sync #(
    .T     (fetch_entry_t),
    .DEPTH (BUF_DEPTH)
  ) u_resp_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (buf_push),
    .din   (resp_entry),
    .pop   (buf_pop),
    .head  (buf_head),
    .count (cnt)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus random traffic against
// an in-order memory model and a queue of expected {pc, word} pairs.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int MI = 2;
  localparam int BD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         pc_valid;
  logic         pc_ready;
  gpreg         pc_data;
  logic         fetched_valid;
  logic         fetched_ready;
  fetch_entry_t fetched_data;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  mem_req_t     mem_req_data;
  logic         mem_resp_valid;
  logic         mem_resp_ready;
  instr         mem_resp_data;

  always #5 clk = ~clk;

  instr_prefetch #(
    .MAX_INFLIGHT (MI),
    .BUF_DEPTH    (BD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .pc_data        (pc_data),
    .fetched_valid  (fetched_valid),
    .fetched_ready  (fetched_ready),
    .fetched_data   (fetched_data),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data)
  );

  typedef struct { gpreg a; int due; bit killed; } mreq_t;
  typedef struct { gpreg pc; bit resp; } ent_t;

  mreq_t memq[$];
  ent_t  expq[$];
  gpreg  log_pc[$];
  int    log_cyc[$];

  int   cyc, total, passed, issued, last_issue;
  int   lat_lo, lat_hi, pc_budget;
  gpreg next_pc;
  bit   rand_pcv;
  logic last_fv;

  function automatic instr word(input gpreg a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step();
    bit cani, rlive, fv, issue;
    pc_valid = (pc_budget > 0) && (!rand_pcv || $urandom_range(3, 0) != 0);
    pc_data  = next_pc;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    rlive = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = word(memq[0].a);
      rlive = !memq[0].killed && !flush;
    end
    cani  = !flush && memq.size() < MI && expq.size() < BD;
    fv    = !flush && expq.size() > 0 && (expq[0].resp || rlive);
    issue = pc_valid && mem_req_ready && cani;
    @(negedge clk);
    check("resp_ready", mem_resp_ready, 1);
    check("pc_ready", pc_ready, mem_req_ready && cani);
    check("req_valid", mem_req_valid, pc_valid && cani);
    check("fetched_valid", fetched_valid, fv);
    if (fv) begin
      check("fetched_pc", fetched_data.pc, expq[0].pc);
      check("fetched_raw", fetched_data.raw, word(expq[0].pc));
    end
    if (issue) check("req_addr", {mem_req_data.we, mem_req_data.a}, {1'b0, pc_data});
    last_fv = fetched_valid;
    if (mem_resp_valid) begin
      memq.delete(0);
      if (rlive) begin
        for (int i = 0; i < expq.size(); i++) begin
          if (!expq[i].resp) begin
            expq[i].resp = 1'b1;
            break;
          end
        end
      end
    end
    if (flush) begin
      expq.delete();
      foreach (memq[i]) memq[i].killed = 1'b1;
    end else if (fv && fetched_ready) begin
      log_pc.push_back(expq[0].pc);
      log_cyc.push_back(cyc);
      expq.delete(0);
    end
    if (issue) begin
      memq.push_back('{pc_data, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
      expq.push_back('{pc_data, 1'b0});
      issued++;
      last_issue = cyc;
      pc_budget--;
      next_pc = pc_data + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int bcyc, base;
    total = 0; passed = 0; issued = 0; cyc = 0; last_issue = 0;
    lat_lo = 1; lat_hi = 1; pc_budget = 0; rand_pcv = 1'b0;
    next_pc = 32'h0; last_fv = 1'b0;
    rst = 1'b1; pc_valid = 1'b1; pc_data = 32'h40; fetched_ready = 1'b1;
    flush = 1'b0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #2;
    check("rst_fetched_valid", fetched_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_pc_ready", pc_ready, 0);
    check("rst_resp_ready", mem_resp_ready, 1);
    repeat (2) @(posedge clk);
    #3;
    pc_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // bypass: latency 1, three back-to-back pcs
    lat_lo = 1; lat_hi = 1; next_pc = 32'h100; pc_budget = 3;
    base = issued; bcyc = cyc; log_pc.delete(); log_cyc.delete();
    repeat (6) step();
    check("byp_issued", issued - base, 3);
    check("byp_count", log_pc.size(), 3);
    for (int i = 0; i < log_pc.size() && i < 3; i++)
      check("byp_pc", log_pc[i], 32'h100 + 32'(4 * i));
    if (log_cyc.size() == 3) begin
      check("byp_lat", log_cyc[0] - bcyc, 1);
      check("byp_consec", log_cyc[2] - log_cyc[0], 2);
    end

    // backpressure: decode stalled for six cycles
    fetched_ready = 1'b0; next_pc = 32'h600; pc_budget = 100; base = issued;
    repeat (6) step();
    check("bp_issued", issued - base, BD);
    pc_budget = 0; fetched_ready = 1'b1; log_pc.delete(); log_cyc.delete();
    repeat (6) step();
    check("bp_drained", log_pc.size(), BD);
    for (int i = 0; i < log_pc.size() && i < BD; i++)
      check("bp_pc", log_pc[i], 32'h600 + 32'(4 * i));

    // flush with two requests in flight
    lat_lo = 5; lat_hi = 5; next_pc = 32'h200; pc_budget = 2;
    base = issued; bcyc = cyc;
    repeat (2) step();
    check("ff_issued", issued - base, 2);
    next_pc = 32'h400; pc_budget = 1; flush = 1'b1;
    step();
    flush = 1'b0; log_pc.delete(); log_cyc.delete();
    repeat (14) step();
    check("ff_count", log_pc.size(), 1);
    if (log_pc.size() > 0) check("ff_pc", log_pc[0], 32'h400);
    check("ff_issue_cyc", last_issue - bcyc, 6);

    // flush coinciding with the first response
    lat_lo = 2; lat_hi = 2; next_pc = 32'h200; pc_budget = 2; bcyc = cyc;
    repeat (2) step();
    next_pc = 32'h400; pc_budget = 1; flush = 1'b1;
    step();
    check("fr_no_valid", last_fv, 0);
    flush = 1'b0; log_pc.delete(); log_cyc.delete();
    repeat (8) step();
    check("fr_count", log_pc.size(), 1);
    if (log_pc.size() > 0) check("fr_pc", log_pc[0], 32'h400);
    check("fr_issue_cyc", last_issue - bcyc, 3);

    // asynchronous reset with one buffered entry
    lat_lo = 1; lat_hi = 1; fetched_ready = 1'b0; next_pc = 32'h300; pc_budget = 1;
    repeat (3) step();
    check("pre_rst_valid", last_fv, 1);
    pc_valid = 1'b1; mem_req_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_fetched_valid", fetched_valid, 0);
    check("mid_rst_req_valid", mem_req_valid, 0);
    check("mid_rst_pc_ready", pc_ready, 0);
    check("mid_rst_resp_ready", mem_resp_ready, 1);
    memq.delete(); expq.delete();
    @(posedge clk);
    #2;
    rst = 1'b0; pc_valid = 1'b0;
    @(posedge clk);
    #1;
    next_pc = 32'h500; pc_budget = 1; fetched_ready = 1'b1;
    log_pc.delete(); log_cyc.delete();
    repeat (4) step();
    check("post_rst_count", log_pc.size(), 1);
    if (log_pc.size() > 0) check("post_rst_pc", log_pc[0], 32'h500);

    // random traffic
    lat_lo = 1; lat_hi = 5; rand_pcv = 1'b1; pc_budget = 1000000;
    next_pc = 32'h1000; log_pc.delete(); log_cyc.delete();
    repeat (3000) begin
      fetched_ready = ($urandom_range(9, 0) < 7);
      mem_req_ready = ($urandom_range(9, 0) < 8);
      flush = ($urandom_range(19, 0) == 0);
      if (flush) next_pc = {14'h0, 16'($urandom_range(16'hffff, 0)), 2'b00};
      step();
    end
    flush = 1'b0; pc_budget = 0; rand_pcv = 1'b0;
    fetched_ready = 1'b1; mem_req_ready = 1'b1;
    repeat (20) step();
    check("rnd_no_loss", expq.size(), 0);
    check("rnd_mem_idle", memq.size(), 0);
    check("rnd_progress", log_pc.size() > 100, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
